// File: rtl/ccc_reconfig_pkg.sv
// Shared types and constants for the CCC/PLL APB reconfiguration master.
package ccc_reconfig_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WR_SETUP,
    WR_ACCESS,
    RD_SETUP,
    RD_ACCESS,
    HOLD,
    WAIT_LOCK,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/ccc_lock_filter.sv
// Synchronizes the asynchronous CCC LOCK and qualifies it as stable after
// LOCK_STABLE consecutive high samples while enabled.
module ccc_lock_filter #(
  parameter int LOCK_STABLE = 8
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic en,
  input  logic lock,
  output logic lock_stable
);

  localparam int CW = $clog2(LOCK_STABLE + 1);

  logic          lock_s1;
  logic          lock_s2;
  logic [CW-1:0] stab_cnt;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      lock_s1  <= 1'b0;
      lock_s2  <= 1'b0;
      stab_cnt <= CW'(LOCK_STABLE);
    end else begin
      lock_s1 <= lock;
      lock_s2 <= lock_s1;
      // any low sample (or leaving WAIT_LOCK) restarts the stability window
      if (!en || !lock_s2)
        stab_cnt <= CW'(LOCK_STABLE);
      else if (stab_cnt != '0)
        stab_cnt <= stab_cnt - CW'(1);
    end
  end

  assign lock_stable = en && (stab_cnt == '0);

endmodule

// File: rtl/ccc_apb_reconfig_master.sv
// APB initiator that streams config bytes into a CCC/PLL, optionally reads
// each back, holds the PLL in reset during the update, then waits for lock.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; PLL_ARST_N released
// LOAD      | cfg_ready high, waiting for the next config byte
// WR_SETUP  | APB write setup phase
// WR_ACCESS | APB write access phase
// RD_SETUP  | APB readback setup phase (VERIFY only)
// RD_ACCESS | APB readback access phase, PRDATA compared
// HOLD      | PLL_ARST_N kept low for ARST_CYCLES after the last write
// WAIT_LOCK | PLL released, waiting for stable lock or timeout
// DONE      | one-cycle done pulse
// ERR       | sticky error, PLL held in reset until the next start
module ccc_apb_reconfig_master
  import ccc_reconfig_pkg::*;
#(
  parameter int VERIFY       = 1,
  parameter int ARST_CYCLES  = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  output logic              PLL_ARST_N,
  input  logic              LOCK,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t      state;
  logic        last_q;
  logic [15:0] hold_cnt;
  logic [15:0] to_cnt;
  logic        lock_stable;

  ccc_lock_filter #(.LOCK_STABLE(LOCK_STABLE)) u_lock_filter (
    .pclk        (PCLK),
    .preset_n    (PRESET_N),
    .en          (state == WAIT_LOCK),
    .lock        (LOCK),
    .lock_stable (lock_stable)
  );

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state      <= IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PLL_ARST_N <= 1'b1;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      last_q     <= 1'b0;
      hold_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state      <= LOAD;
            cfg_ready  <= 1'b1;
            PLL_ARST_N <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
          end
        end
        LOAD: begin
          if (cfg_valid && cfg_ready) begin
            cfg_ready <= 1'b0;
            PADDR     <= cfg_addr;
            PWDATA    <= cfg_data;
            last_q    <= cfg_last;
            PSEL      <= 1'b1;
            PWRITE    <= 1'b1;
            state     <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          PENABLE <= 1'b1;
          state   <= WR_ACCESS;
        end
        WR_ACCESS: begin
          PENABLE <= 1'b0;
          if (VERIFY != 0) begin
            PWRITE <= 1'b0;
            state  <= RD_SETUP;
          end else begin
            PSEL <= 1'b0;
            if (last_q) begin
              hold_cnt <= 16'(ARST_CYCLES - 1);
              state    <= HOLD;
            end else begin
              cfg_ready <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        RD_SETUP: begin
          PENABLE <= 1'b1;
          state   <= RD_ACCESS;
        end
        RD_ACCESS: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (PRDATA != PWDATA) begin
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_MISMATCH;
            state    <= ERR;
          end else if (last_q) begin
            hold_cnt <= 16'(ARST_CYCLES - 1);
            state    <= HOLD;
          end else begin
            cfg_ready <= 1'b1;
            state     <= LOAD;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            PLL_ARST_N <= 1'b1;
            to_cnt     <= 16'(LOCK_TIMEOUT - 1);
            state      <= WAIT_LOCK;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        WAIT_LOCK: begin
          // stable lock takes priority over a coincident timeout
          if (lock_stable) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (to_cnt == '0) begin
            busy       <= 1'b0;
            err        <= 1'b1;
            err_code   <= ERR_TIMEOUT;
            PLL_ARST_N <= 1'b0;
            state      <= ERR;
          end else begin
            to_cnt <= to_cnt - 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_apb_reconfig_master.sv
// Directed bench for ccc_apb_reconfig_master: a write-only instance and a
// readback instance share stimulus; each is started separately.
module tb_ccc_apb_reconfig_master;

  logic       PCLK = 1'b0;
  logic       PRESET_N;
  logic       start0, start1;
  logic       cfg_valid;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       LOCK;

  logic       rdy0, psel0, pen0, pwr0, arst0, busy0, done0, err0;
  logic [5:0] paddr0;
  logic [7:0] pwdata0;
  logic [1:0] ecode0;
  logic       rdy1, psel1, pen1, pwr1, arst1, busy1, done1, err1;
  logic [5:0] paddr1;
  logic [7:0] pwdata1, prdata1;
  logic [1:0] ecode1;

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  // readback responder: corrupts address 0x02, echoes everything else
  assign prdata1 = (paddr1 == 6'h02) ? 8'hA4 : pwdata1;

  ccc_apb_reconfig_master #(.VERIFY(0), .LOCK_TIMEOUT(100)) dut0 (
    .PCLK(PCLK), .PRESET_N(PRESET_N), .start(start0), .cfg_valid(cfg_valid),
    .cfg_ready(rdy0), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .PSEL(psel0), .PENABLE(pen0), .PWRITE(pwr0), .PADDR(paddr0), .PWDATA(pwdata0),
    .PRDATA(8'h00), .PLL_ARST_N(arst0), .LOCK(LOCK), .busy(busy0), .done(done0),
    .err(err0), .err_code(ecode0));

  ccc_apb_reconfig_master #(.VERIFY(1), .LOCK_TIMEOUT(100)) dut1 (
    .PCLK(PCLK), .PRESET_N(PRESET_N), .start(start1), .cfg_valid(cfg_valid),
    .cfg_ready(rdy1), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .PSEL(psel1), .PENABLE(pen1), .PWRITE(pwr1), .PADDR(paddr1), .PWDATA(pwdata1),
    .PRDATA(prdata1), .PLL_ARST_N(arst1), .LOCK(LOCK), .busy(busy1), .done(done1),
    .err(err1), .err_code(ecode1));

  typedef struct {
    logic       st, v;
    logic [5:0] a;
    logic [7:0] d;
    logic       l;
    logic       rdy, ps, pe, pw;
    logic [5:0] pa;
    logic [7:0] pd;
    logic       ar, bz, dn;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(logic st, logic v, logic [5:0] a, logic [7:0] d, logic l,
                              logic rdy, logic ps, logic pe, logic pw, logic [5:0] pa,
                              logic [7:0] pd, logic ar, logic bz, logic dn);
    vec_t r;
    r.st = st; r.v = v; r.a = a; r.d = d; r.l = l;
    r.rdy = rdy; r.ps = ps; r.pe = pe; r.pw = pw; r.pa = pa; r.pd = pd;
    r.ar = ar; r.bz = bz; r.dn = dn;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic feed(input bit sel, input logic [5:0] a, input logic [7:0] d, input logic l);
    int n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(sel ? rdy1 : rdy0) && n < 20);
    chk("feed cfg_ready seen", sel ? rdy1 : rdy0, 1'b1);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; cfg_last = l;
    @(negedge PCLK);
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge PCLK);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge PCLK);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_arst0_high(output int ok);
    int n = 0;
    ok = 0;
    while (n < 100 && !ok) begin
      @(negedge PCLK);
      n++;
      if (arst0) ok = 1;
    end
    chk("PLL_ARST_N release seen", ok, 1);
  endtask

  initial begin
    int ok, n, k, doff, dcnt, apb_after, rdy_seen, rd_ok;

    PRESET_N = 1'b0; start0 = 1'b0; start1 = 1'b0; cfg_valid = 1'b0;
    cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0; LOCK = 1'b0;

    tbl[0] = mk(1, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 6'h00, 8'h00, 1, 0, 0);
    tbl[1] = mk(0, 1, 6'h02, 8'hA5, 0, 1, 0, 0, 0, 6'h00, 8'h00, 0, 1, 0);
    tbl[2] = mk(0, 1, 6'h05, 8'h3C, 1, 0, 1, 0, 1, 6'h02, 8'hA5, 0, 1, 0);
    tbl[3] = mk(0, 1, 6'h05, 8'h3C, 1, 0, 1, 1, 1, 6'h02, 8'hA5, 0, 1, 0);
    tbl[4] = mk(0, 1, 6'h05, 8'h3C, 1, 1, 0, 0, 0, 6'h00, 8'h00, 0, 1, 0);
    tbl[5] = mk(0, 0, 6'h00, 8'h00, 0, 0, 1, 0, 1, 6'h05, 8'h3C, 0, 1, 0);
    tbl[6] = mk(0, 0, 6'h00, 8'h00, 0, 0, 1, 1, 1, 6'h05, 8'h3C, 0, 1, 0);
    for (int i = 7; i <= 22; i++)
      tbl[i] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 6'h00, 8'h00, 0, 1, 0);
    for (int i = 23; i <= 31; i++)
      tbl[i] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 6'h00, 8'h00, 1, 1, 0);
    tbl[32] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 6'h00, 8'h00, 1, 0, 1);
    tbl[33] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 6'h00, 8'h00, 1, 0, 0);

    // reset state
    repeat (3) @(negedge PCLK);
    chk("reset PSEL", psel0, 1'b0);
    chk("reset PENABLE", pen0, 1'b0);
    chk("reset PWRITE", pwr0, 1'b0);
    chk("reset PADDR", paddr0, 6'h00);
    chk("reset PWDATA", pwdata0, 8'h00);
    chk("reset PLL_ARST_N", arst0, 1'b1);
    chk("reset cfg_ready", rdy0, 1'b0);
    chk("reset busy/done/err", {busy0, done0, err0}, 3'b000);
    chk("reset err_code", ecode0, 2'd0);
    chk("reset dut1 PLL_ARST_N", arst1, 1'b1);
    PRESET_N = 1'b1;

    // cfg_valid in IDLE ignored, start during LOAD ignored
    cfg_valid = 1'b1; cfg_addr = 6'h02; cfg_data = 8'hA5;
    repeat (4) @(negedge PCLK);
    chk("idle cfg_ready", rdy0, 1'b0);
    chk("idle busy", busy0, 1'b0);
    chk("idle PSEL", psel0, 1'b0);
    cfg_valid = 1'b0;
    pulse_start(0);
    chk("load cfg_ready", rdy0, 1'b1);
    chk("load busy", busy0, 1'b1);
    chk("load PLL_ARST_N", arst0, 1'b0);
    start0 = 1'b1;
    @(negedge PCLK);
    start0 = 1'b0;
    @(negedge PCLK);
    chk("start in LOAD ignored cfg_ready", rdy0, 1'b1);
    chk("start in LOAD ignored PSEL", psel0, 1'b0);

    // async reset during WR_ACCESS
    feed(0, 6'h02, 8'hA5, 1'b0);
    chk("WR_SETUP PSEL/PENABLE", {psel0, pen0}, 2'b10);
    @(negedge PCLK);
    chk("WR_ACCESS PSEL/PENABLE", {psel0, pen0}, 2'b11);
    #1 PRESET_N = 1'b0;
    #1;
    chk("mid-reset PSEL", psel0, 1'b0);
    chk("mid-reset PENABLE", pen0, 1'b0);
    chk("mid-reset PLL_ARST_N", arst0, 1'b1);
    chk("mid-reset busy", busy0, 1'b0);
    @(negedge PCLK);
    PRESET_N = 1'b1;
    LOCK = 1'b1;
    repeat (4) @(negedge PCLK);

    // two-byte write-only sequence, cycle by cycle
    for (int i = 0; i < 34; i++) begin
      @(negedge PCLK);
      start0 = tbl[i].st; cfg_valid = tbl[i].v; cfg_addr = tbl[i].a;
      cfg_data = tbl[i].d; cfg_last = tbl[i].l;
      chk($sformatf("row%0d cfg_ready", i), rdy0, tbl[i].rdy);
      chk($sformatf("row%0d PSEL", i), psel0, tbl[i].ps);
      chk($sformatf("row%0d PENABLE", i), pen0, tbl[i].pe);
      chk($sformatf("row%0d PLL_ARST_N", i), arst0, tbl[i].ar);
      chk($sformatf("row%0d busy", i), busy0, tbl[i].bz);
      chk($sformatf("row%0d done", i), done0, tbl[i].dn);
      if (tbl[i].ps) begin
        chk($sformatf("row%0d PWRITE", i), pwr0, tbl[i].pw);
        chk($sformatf("row%0d PADDR", i), paddr0, tbl[i].pa);
        chk($sformatf("row%0d PWDATA", i), pwdata0, tbl[i].pd);
      end
    end
    start0 = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;

    // lock timeout: err 100 cycles after PLL release
    LOCK = 1'b0;
    pulse_start(0);
    feed(0, 6'h03, 8'h11, 1'b1);
    wait_arst0_high(ok);
    n = 0;
    while (n < 300 && !err0) begin
      @(negedge PCLK);
      n++;
    end
    chk("timeout cycles after HOLD", n, 100);
    chk("timeout err_code", ecode0, 2'd2);
    chk("timeout busy", busy0, 1'b0);

    // LOCK glitch restarts the stability window
    LOCK = 1'b1;
    pulse_start(0);
    chk("restart clears err", {err0, ecode0}, 3'b000);
    feed(0, 6'h04, 8'h22, 1'b1);
    wait_arst0_high(ok);
    doff = 0; dcnt = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge PCLK);
      if (done0) begin
        dcnt++;
        if (doff == 0) doff = j;
      end
      if (j == 4) LOCK = 1'b0;
      if (j == 5) LOCK = 1'b1;
    end
    chk("glitch done offset", doff, 16);
    chk("glitch done pulses", dcnt, 1);

    // readback mismatch on the verifying instance
    pulse_start(1);
    feed(1, 6'h02, 8'hA5, 1'b0);
    cfg_valid = 1'b1; cfg_addr = 6'h05; cfg_data = 8'h3C; cfg_last = 1'b1;
    k = 0; rd_ok = 0;
    while (k < 20 && !err1) begin
      @(negedge PCLK);
      k++;
      if (k == 2 && psel1 && !pen1 && !pwr1 && paddr1 == 6'h02) rd_ok = 1;
    end
    chk("readback setup seen", rd_ok, 1);
    chk("mismatch err latency", k, 4);
    chk("mismatch err_code", ecode1, 2'd1);
    chk("mismatch PLL_ARST_N", arst1, 1'b0);
    chk("mismatch busy", busy1, 1'b0);
    apb_after = 0; rdy_seen = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (psel1 || pen1) apb_after++;
      if (rdy1) rdy_seen++;
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    chk("no APB after mismatch", apb_after, 0);
    chk("no cfg_ready after mismatch", rdy_seen, 0);
    chk("err sticky", {err1, arst1}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
